// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared types and constants for the RV core front end.
//   NOP_INSTR        - addi x0,x0,0, presented to decode when nothing is buffered
//   DEFAULT_RESET_PC - default first fetch address after reset
//   fetch_entry_t    - one buffered fetch: instruction word plus its PC
//   fetch_state_e    - fetch sequencer states
//   word_align()     - clears the byte-offset bits of an address
package rv_core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer between instruction memory and decode.
//   clk, rst_n    - clock, asynchronous active-low reset
//   flush_i       - drop every entry (wins over push and pop)
//   push_i        - write push_entry_i at the tail
//   pop_i         - retire the head entry
//   count_o       - number of buffered entries (0..DEPTH)
//   head_o        - oldest entry, driven straight from storage flops
// Push and pop may happen on the same edge at any occupancy, including full.
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_s, push_s;

  // Pointer and occupancy next-state; a pop frees the slot a full-FIFO push reuses.
  always_comb begin
    pop_s    = pop_i && (count_q != {CW{1'b0}});
    push_s   = push_i && ((count_q != FULL_C) || pop_s);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; reset contents make the idle head read as a NOP at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
      end
    end else if (push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control decoder.
//   clk, rst_n                       - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        - in-order fetch request channel
//   imem_rsp_valid/data              - in-order response words
//   redirect_valid/redirect_pc       - restart fetch at a new PC (branch/jump/trap/mret)
//   stall                            - decode cannot take an instruction this cycle
//   instr_valid/instr/instr_pc       - instruction presented to decode (NOP when empty)
//   fetch_misaligned                 - one-cycle pulse after a redirect to a non-word PC
// Requests are credit limited so outstanding requests plus buffered words never
// exceed DEPTH; stale responses after a redirect are dropped via discard_cnt.
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e   state_q;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]  outs_q, outs_d;
  logic [CW-1:0]  discard_q, discard_d;
  logic           misaligned_q, misaligned_d;

  logic [CW-1:0]  fifo_count_s;
  logic [CW-1:0]  occupancy_s;
  logic           head_valid_s, pop_s, push_s, rsp_s;
  logic           req_valid_s, req_acc_s;
  fetch_entry_t   head_s, push_entry_s;

  // Credit check and next-state for PC, response PC, outstanding and discard counts.
  always_comb begin
    head_valid_s = (fifo_count_s != {CW{1'b0}});
    pop_s        = head_valid_s && !stall;
    // The head leaving this cycle frees its credit now, which is what lets a
    // 1-cycle memory sustain one instruction per cycle with only two entries.
    occupancy_s  = outs_q + fifo_count_s - CW'(pop_s);
    req_valid_s  = (state_q == ST_RUN) && (occupancy_s < DEPTH_C) && !redirect_valid;
    req_acc_s    = req_valid_s && imem_req_ready;
    // A response with nothing outstanding cannot be ours; ignore it.
    rsp_s        = imem_rsp_valid && (outs_q != {CW{1'b0}});
    outs_d       = outs_q + CW'(req_acc_s) - CW'(rsp_s);

    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    discard_d    = discard_q;
    misaligned_d = 1'b0;
    push_s       = 1'b0;
    push_entry_s = '{pc: rsp_pc_q, instr: imem_rsp_data};

    if (redirect_valid) begin
      pc_d         = word_align(redirect_pc);
      rsp_pc_d     = word_align(redirect_pc);
      // Everything still in flight after this edge belongs to the old path.
      discard_d    = outs_d;
      misaligned_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (req_acc_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_s) begin
        if (discard_q != {CW{1'b0}}) begin
          discard_d = discard_q - CW'(1'b1);
        end else begin
          push_s   = 1'b1;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Sequencer: a single idle cycle after reset release, then run forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_RUN;
        ST_RUN:   state_q <= ST_RUN;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      outs_q       <= {CW{1'b0}};
      discard_q    <= {CW{1'b0}};
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      outs_q       <= outs_d;
      discard_q    <= discard_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .count_o      (fifo_count_s),
    .head_o       (head_s)
  );

  assign imem_req_valid   = req_valid_s;
  assign imem_req_addr    = pc_q;
  assign instr_valid      = head_valid_s;
  assign instr            = head_valid_s ? head_s.instr : NOP_INSTR;
  assign instr_pc         = head_s.pc;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit with an in-order
// memory model and a program-order reference (expected next PC per consumed
// instruction, expected next request address).
module tb_fetch_unit;
  import rv_core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        fetch_misaligned;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model: accepted addresses in order, with the edge index they may return on
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          edge_no = 0;
  int          lat_min = 1, lat_max = 1;
  int          ready_pct = 100, rsp_pct = 100, stall_pct = 0;

  // reference model
  logic [31:0] exp_pc, exp_req;
  logic        redir_pend = 1'b0;
  logic        mis_exp = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then apply the edge to the models.
  task automatic cycle(input logic do_redir, input logic [31:0] tgt);
    logic        acc, rsp, cons;
    logic [31:0] addr_s;
    redirect_valid = do_redir;
    redirect_pc    = tgt;
    stall          = ($urandom_range(99) < stall_pct);
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if (mq_addr.size() > 0 && mq_due[0] <= edge_no && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (redir_pend) begin
      check("valid_after_redirect", {31'd0, instr_valid}, 32'd0);
      check("misaligned_pulse", {31'd0, fetch_misaligned}, {31'd0, mis_exp});
    end else begin
      check("misaligned_idle", {31'd0, fetch_misaligned}, 32'd0);
    end
    if (!instr_valid) check("nop_when_empty", instr, NOP_INSTR);
    acc    = imem_req_valid && imem_req_ready;
    rsp    = imem_rsp_valid;
    cons   = instr_valid && !stall;
    addr_s = imem_req_addr;
    if (acc) check("req_addr", addr_s, exp_req);
    if (do_redir) check("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
    if (cons) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr_data", instr, mem_word(exp_pc));
    end
    @(posedge clk);
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (acc) begin
      mq_addr.push_back(addr_s);
      mq_due.push_back(edge_no + int'($urandom_range(lat_max, lat_min)));
    end
    if (do_redir) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
    end else begin
      if (cons) exp_pc  = exp_pc + 32'd4;
      if (acc)  exp_req = exp_req + 32'd4;
    end
    redir_pend = do_redir;
    mis_exp    = (tgt[1:0] != 2'b00);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic reset_models();
    mq_addr.delete();
    mq_due.delete();
    exp_pc     = RST_PC;
    exp_req    = RST_PC;
    redir_pend = 1'b0;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, RST_PC);
    check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, NOP_INSTR);
    check({tag, "_instr_pc"}, instr_pc, RST_PC);
    check({tag, "_misaligned"}, {31'd0, fetch_misaligned}, 32'd0);
  endtask

  // Run until the first valid instruction (bounded) and check it is the target.
  task automatic expect_first(input string tag, input logic [31:0] target);
    logic found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 32'd0);
    end
    check({tag, "_found"}, {31'd0, found}, 32'd1);
    if (found) check({tag, "_pc"}, instr_pc, target);
  endtask

  initial begin
    int          first;
    logic [31:0] held_pc;
    idle_inputs();
    reset_models();
    rst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // startup with a 1-cycle always-ready memory
    imem_req_ready = 1'b1;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid && first < 0) first = k;
      cycle(1'b0, 32'd0);
    end
    check("startup_latency", 32'(first), 32'd3);
    for (int k = 0; k < 10; k++) begin
      check("continuous_valid", {31'd0, instr_valid}, 32'd1);
      cycle(1'b0, 32'd0);
    end

    // stall with FIFO full
    stall_pct = 100;
    held_pc   = instr_pc;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'd0);
      check("stall_held_pc", instr_pc, held_pc);
      check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    stall_pct = 0;
    for (int k = 0; k < 10; k++) cycle(1'b0, 32'd0);

    // 3-cycle memory, redirect with requests outstanding
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 8; k++) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0100);
    check("redir_addr", imem_req_addr, 32'h0000_0100);
    expect_first("redir_lat3", 32'h0000_0100);

    // redirect coinciding with a response in a 1-cycle stream
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 8; k++) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0200);
    check("redir2_addr", imem_req_addr, 32'h0000_0200);
    expect_first("redir_coincide", 32'h0000_0200);

    // misaligned redirect
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0102);
    check("misaligned_addr", imem_req_addr, 32'h0000_0100);
    expect_first("misaligned_first", 32'h0000_0100);

    // PC wrap
    cycle(1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 12; k++) cycle(1'b0, 32'd0);
    check("wrap_progress", {31'd0, (exp_pc < 32'h0000_0100) && (exp_pc >= 32'h0000_0008)}, 32'd1);

    // randomized traffic
    ready_pct = 70; rsp_pct = 80; stall_pct = 25; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(99) < 4) cycle(1'b1, $urandom);
      else cycle(1'b0, 32'd0);
    end

    // asynchronous reset mid-stream
    ready_pct = 100; rsp_pct = 100; stall_pct = 0; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 12; k++) cycle(1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_models();
    rst_n = 1'b1;
    expect_first("restart", RST_PC);
    for (int k = 0; k < 10; k++) cycle(1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
